// File: rtl/display_adder_mux_pkg.sv
// Shared definitions for the adder/display block: seven-segment glyphs
// (active-low, {g,f,e,d,c,b,a}), FSM state encodings and the glyph decoder.
package display_adder_mux_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // BCD digit to glyph; anything above 9 is unreachable and shows blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/display_adder_mux_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble converter. One add-3/shift
// iteration per clock after load; WIDTH iterations in total. valid is high
// during the final iteration so the caller can leave its wait state on the
// same edge the last digit settles.
module bin2bcd_seq #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid
);

  localparam int CNT_W = $clog2(WIDTH + 1) + 1;

  logic [WIDTH-1:0]    shift_reg;
  logic [4*DIGITS-1:0] bcd_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [4*DIGITS-1:0] adj;

  // Add 3 to every BCD nibble that is 5 or more before the next shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                              bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Load the operand, then shift one binary bit into the BCD field per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
    end else if (load) begin
      shift_reg <= bin;
      bcd_reg   <= '0;
      cnt_reg   <= CNT_W'(WIDTH);
    end else if (cnt_reg != '0) begin
      bcd_reg   <= {adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      cnt_reg   <= cnt_reg - 1'b1;
    end
  end

  assign bcd   = bcd_reg;
  assign valid = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/display_adder_mux.sv
// display_adder_mux: adds A+B on start, converts the sum to BCD and scans
// it onto a common-anode multiplexed seven-segment display.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module display_adder_mux
  import display_adder_mux_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [WIDTH:0]    sum_out,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t              state_reg, state_next;
  logic                load;
  logic                valid;
  logic [WIDTH:0]      sum;
  logic [WIDTH:0]      sum_out_reg;
  logic [4*DIGITS-1:0] bcd;
  logic [4*DIGITS-1:0] disp_reg;
  logic [DIV_W-1:0]    div_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [6:0]          seg_reg;
  logic [DIGITS-1:0]   an_reg;
  logic [3:0]          digit [DIGITS];
  logic [DIGITS-1:0]   blank;

  assign sum = {1'b0, A} + {1'b0, B};

  bin2bcd_seq #(
    .WIDTH  (WIDTH + 1),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .bin   (sum),
    .bcd   (bcd),
    .valid (valid)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and status outputs; start is only honoured in IDLE.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        busy = 1'b1;
        if (valid) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture the binary sum on acceptance; publish BCD only once complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_out_reg <= '0;
      disp_reg    <= '0;
    end else begin
      if (load) sum_out_reg <= sum;
      if (state_reg == ST_DONE) disp_reg <= bcd;
    end
  end

  // Slot divider and digit index; index advances when the divider wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg <= '0;
      idx_reg <= '0;
    end else if (div_reg == DIV_W'(REFRESH_DIV - 1)) begin
      div_reg <= '0;
      idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  // Split the display register into digits and work out leading-zero blanking.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit[gi] = disp_reg[4*gi +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_lsd
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = (disp_reg[4*DIGITS-1:4*gi] == '0);
      end
`else
      assign blank[gi] = 1'b0;
`endif
    end
  endgenerate

  // seg and an are registered together so no ghost glyph appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_reg <= SEG_BLANK;
      an_reg  <= '1;
    end else begin
      an_reg  <= ~(DIGITS'(1) << idx_reg);
      seg_reg <= blank[idx_reg] ? SEG_BLANK : seg_decode(digit[idx_reg]);
    end
  end

  assign sum_out = sum_out_reg;
  assign seg     = seg_reg;
  assign an      = an_reg;

endmodule

// File: tb/tb_display_adder_mux.sv
// Directed self-checking bench for display_adder_mux (WIDTH=4, DIGITS=2,
// REFRESH_DIV=4). Honours LEADING_ZERO_BLANK_EN when defined.
module tb_display_adder_mux;

  localparam int W = 4;
  localparam int D = 2;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W:0]   sum_out;
  logic [6:0]   seg;
  logic [D-1:0] an;

  int n_assert = 0;
  int n_fail   = 0;
  int dones;

  always #5 clk = ~clk;

  display_adder_mux #(.WIDTH(W), .DIGITS(D), .REFRESH_DIV(R)) dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .seg     (seg),
    .an      (an)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Wait (bounded) until the given anode pattern is active, then check its glyph.
  task automatic show(input string tag, input logic [D-1:0] an_exp, input logic [6:0] seg_exp);
    int k;
    k = 0;
    while (an !== an_exp && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_an"}, an, an_exp);
    chk({tag, "_seg"}, seg, seg_exp);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum_out, 5'd0);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 2'b11);
    rst = 1'b0;

    // 1: 9 + 8 = 17, done in cycle 6
    start_op(4'd9, 4'd8);
    chk("t1_busy_c1", busy, 1'b1);
    chk("t1_done_c1", done, 1'b0);
    repeat (4) tick();
    chk("t1_done_c5", done, 1'b0);
    tick();
    chk("t1_done_c6", done, 1'b1);
    chk("t1_sum", sum_out, 5'd17);
    tick();
    chk("t1_done_c7", done, 1'b0);
    chk("t1_busy_c7", busy, 1'b0);
    tick();
    show("t1_units", 2'b10, 7'b1111000);
    show("t1_tens", 2'b01, 7'b1111001);

    // 2: 15 + 15 = 30, carry kept
    start_op(4'd15, 4'd15);
    repeat (5) tick();
    chk("t2_done", done, 1'b1);
    chk("t2_sum", sum_out, 5'd30);
    repeat (2) tick();
    show("t2_units", 2'b10, 7'b1000000);
    show("t2_tens", 2'b01, 7'b0110000);

    // 4: second start during conversion is ignored
    A = 4'd9; B = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 4'd1; B = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      tick();
    end
    chk("t4_done_count", dones, 1);
    chk("t4_sum", sum_out, 5'd17);
    show("t4_units", 2'b10, 7'b1111000);
    show("t4_tens", 2'b01, 7'b1111001);

    // 3: scan alternates every R clocks for 8 slots
    show("t3_sync01", 2'b01, 7'b1111001);
    show("t3_sync10", 2'b10, 7'b1111000);
    for (int s = 0; s < 8; s++) begin
      chk($sformatf("t3_slot%0d_start", s), an, (s % 2 == 0) ? 2'b10 : 2'b01);
      repeat (R - 1) tick();
      chk($sformatf("t3_slot%0d_end", s), an, (s % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end

    // 5: reset in cycle 3 of a conversion
    start_op(4'd15, 4'd15);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_sum", sum_out, 5'd0);
    chk("t5_seg", seg, 7'h7F);
    chk("t5_an", an, 2'b11);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      tick();
    end
    chk("t5_no_done", dones, 0);
    show("t5_units", 2'b10, 7'b1000000);
`ifdef LEADING_ZERO_BLANK_EN
    show("t5_tens", 2'b01, 7'h7F);
`else
    show("t5_tens", 2'b01, 7'b1000000);
`endif

    // 6: 0 + 5 = 5, leading-zero handling on the tens digit
    start_op(4'd0, 4'd5);
    repeat (5) tick();
    chk("t6_done", done, 1'b1);
    chk("t6_sum", sum_out, 5'd5);
    repeat (2) tick();
    show("t6_units", 2'b10, 7'b0010010);
`ifdef LEADING_ZERO_BLANK_EN
    show("t6_tens", 2'b01, 7'h7F);
`else
    show("t6_tens", 2'b01, 7'b1000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
